// File: rtl/aes_seq_pkg.sv
// Shared types for the AES command sequencer: host opcodes, FSM states,
// error codes and the 128-bit block type.
package aes_seq_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    OP_NOP      = 2'd0,
    OP_LOAD_KEY = 2'd1,
    OP_ENCRYPT  = 2'd2,
    OP_DECRYPT  = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_REQ,
    ST_KEY_WAIT,
    ST_BLK_START,
    ST_BLK_WAIT,
    ST_CAPTURE
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_NO_KEY  = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_ABORT   = 2'd3
  } err_e;

endpackage

// File: rtl/aes_seq_timeout.sv
// Loadable down-counter supervising core latency; expired is raised in the
// TIMEOUT_CYCLES-1'th cycle after the cycle in which clr was high.
module aes_seq_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The clr cycle itself counts as the first cycle, hence the -2 load value.
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0) && !clr;

endmodule

// File: rtl/aes_seq_ctrl.sv
// Command sequencer between the AES register file and the AES core: key load,
// encrypt/decrypt handshakes, timeout supervision, result/status latching.
module aes_seq_ctrl
  import aes_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 32
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [127:0]     key_in,
  input  logic [127:0]     blk_in,
  input  logic             abort,
  output logic [127:0]     core_key,
  output logic             core_key_load,
  input  logic             core_key_ready,
  output logic [127:0]     core_din,
  output logic             core_dec,
  output logic             core_start,
  input  logic             core_done,
  input  logic [127:0]     core_dout,
  output logic [127:0]     res_data,
  output logic             res_valid,
  output logic             busy,
  output logic             key_loaded,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] blk_count,
  output logic             irq
);

  state_e           state_q, state_d;
  block_t           core_key_q, core_key_d;
  block_t           core_din_q, core_din_d;
  block_t           res_data_q, res_data_d;
  logic             core_key_load_q, core_key_load_d;
  logic             core_start_q, core_start_d;
  logic             core_dec_q, core_dec_d;
  logic             res_valid_q, res_valid_d;
  logic             key_loaded_q, key_loaded_d;
  err_e             err_q, err_d;
  logic [CNT_W-1:0] blk_count_q, blk_count_d;
  logic             irq_q, irq_d;
  logic             irq_evt;
  logic             to_clr, to_expired;
  cmd_op_e          op;

  assign op     = cmd_op_e'(cmd_op);
  assign to_clr = (state_q == ST_KEY_REQ) || (state_q == ST_BLK_START);

  aes_seq_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (ACLK),
    .srst   (ARESET),
    .clr    (to_clr),
    .expired(to_expired)
  );

  always_comb begin
    state_d      = state_q;
    core_key_d   = core_key_q;
    core_din_d   = core_din_q;
    core_dec_d   = core_dec_q;
    res_data_d   = res_data_q;
    res_valid_d  = res_valid_q;
    key_loaded_d = key_loaded_q;
    err_d        = err_q;
    blk_count_d  = blk_count_q;
    irq_evt      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          err_d       = ERR_NONE;
          res_valid_d = 1'b0;
          case (op)
            OP_NOP: ;
            OP_LOAD_KEY: begin
              core_key_d   = key_in;
              key_loaded_d = 1'b0;
              state_d      = ST_KEY_REQ;
            end
            OP_ENCRYPT, OP_DECRYPT: begin
              if (!key_loaded_q) begin
                err_d   = ERR_NO_KEY;
                irq_evt = 1'b1;
              end else begin
                core_din_d = blk_in;
                core_dec_d = cmd_op[0];
                state_d    = ST_BLK_START;
              end
            end
            default: ;
          endcase
        end
      end
      ST_KEY_REQ:   state_d = ST_KEY_WAIT;
      ST_KEY_WAIT: begin
        if (core_key_ready) begin
          key_loaded_d = 1'b1;
          irq_evt      = 1'b1;
          state_d      = ST_IDLE;
        end else if (to_expired) begin
          err_d        = ERR_TIMEOUT;
          key_loaded_d = 1'b0;
          irq_evt      = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_BLK_START: state_d = ST_BLK_WAIT;
      ST_BLK_WAIT: begin
        if (core_done) begin
          res_data_d  = core_dout;
          res_valid_d = 1'b1;
          blk_count_d = blk_count_q + CNT_W'(1);
          irq_evt     = 1'b1;
          state_d     = ST_CAPTURE;
        end else if (to_expired) begin
          err_d        = ERR_TIMEOUT;
          key_loaded_d = 1'b0;
          irq_evt      = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_CAPTURE:   state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    // Abort overrides anything the wait states decided in the same cycle.
    if (abort && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      err_d        = ERR_ABORT;
      irq_evt      = 1'b1;
      res_data_d   = res_data_q;
      res_valid_d  = res_valid_q;
      blk_count_d  = blk_count_q;
      key_loaded_d = ((state_q == ST_KEY_REQ) || (state_q == ST_KEY_WAIT)) ? 1'b0 : key_loaded_q;
    end

    core_key_load_d = (state_d == ST_KEY_REQ);
    core_start_d    = (state_d == ST_BLK_START);
    irq_d           = irq_evt && !irq_q;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q         <= ST_IDLE;
      core_key_q      <= '0;
      core_din_q      <= '0;
      core_dec_q      <= 1'b0;
      res_data_q      <= '0;
      res_valid_q     <= 1'b0;
      key_loaded_q    <= 1'b0;
      err_q           <= ERR_NONE;
      blk_count_q     <= '0;
      core_key_load_q <= 1'b0;
      core_start_q    <= 1'b0;
      irq_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      core_key_q      <= core_key_d;
      core_din_q      <= core_din_d;
      core_dec_q      <= core_dec_d;
      res_data_q      <= res_data_d;
      res_valid_q     <= res_valid_d;
      key_loaded_q    <= key_loaded_d;
      err_q           <= err_d;
      blk_count_q     <= blk_count_d;
      core_key_load_q <= core_key_load_d;
      core_start_q    <= core_start_d;
      irq_q           <= irq_d;
    end
  end

  assign cmd_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign core_key      = core_key_q;
  assign core_key_load = core_key_load_q;
  assign core_din      = core_din_q;
  assign core_dec      = core_dec_q;
  assign core_start    = core_start_q;
  assign res_data      = res_data_q;
  assign res_valid     = res_valid_q;
  assign key_loaded    = key_loaded_q;
  assign err_code      = err_q;
  assign blk_count     = blk_count_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Bench for aes_seq_ctrl: behavioural AES core model plus a result scoreboard
// filled when block commands are issued and drained on each capture.
module tb_aes_seq_ctrl;
  import aes_seq_pkg::*;

  localparam int TO      = 16;
  localparam int CW      = 2;
  localparam int LAT     = 5;
  localparam int KEY_LAT = 10;

  localparam block_t KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam block_t PT0  = 128'h00112233445566778899aabbccddeeff;
  localparam block_t CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  block_t        key_in = '0;
  block_t        blk_in = '0;
  logic          abort = 1'b0;
  block_t        core_key;
  logic          core_key_load;
  logic          core_key_ready;
  block_t        core_din;
  logic          core_dec;
  logic          core_start;
  logic          core_done;
  block_t        core_dout;
  block_t        res_data;
  logic          res_valid;
  logic          busy;
  logic          key_loaded;
  logic [1:0]    err_code;
  logic [CW-1:0] blk_count;
  logic          irq;

  always #5 ACLK = ~ACLK;

  aes_seq_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .key_in(key_in), .blk_in(blk_in), .abort(abort),
    .core_key(core_key), .core_key_load(core_key_load), .core_key_ready(core_key_ready),
    .core_din(core_din), .core_dec(core_dec), .core_start(core_start),
    .core_done(core_done), .core_dout(core_dout), .res_data(res_data),
    .res_valid(res_valid), .busy(busy), .key_loaded(key_loaded),
    .err_code(err_code), .blk_count(blk_count), .irq(irq)
  );

  typedef struct packed {
    block_t data;
    logic   dec;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   sb_e;
  int     n_checks = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     irq_cnt = 0;
  int     start_cnt = 0;
  int     last_done_c = 0;
  logic   irq_prev = 1'b0;

  int     mcnt = 0;
  int     kcnt = 0;
  logic   model_done = 1'b0;
  logic   key_rdy = 1'b0;
  block_t model_dout = '0;
  bit     model_never = 1'b0;
  logic   man_done = 1'b0;
  block_t man_dout = '0;

  assign core_done      = model_done | man_done;
  assign core_dout      = man_done ? man_dout : model_dout;
  assign core_key_ready = key_rdy;

  function automatic block_t core_fn(input block_t k, input block_t d, input logic dec);
    if (!dec && k == KEY0 && d == PT0) return CT0;
    return {d[63:0], d[127:64]} ^ k ^ (dec ? 128'h5a5a_0000_ffff_1234_0f0f_aaaa_5555_c3c3
                                           : 128'ha5a5_1111_0000_4321_f0f0_5555_aaaa_3c3c);
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  always @(posedge ACLK) cyc <= cyc + 1;

  // Core model: key ready KEY_LAT cycles after key_load, done LAT cycles after start.
  always @(posedge ACLK) begin
    model_done <= 1'b0;
    if (ARESET) begin
      mcnt    <= 0;
      kcnt    <= 0;
      key_rdy <= 1'b0;
    end else begin
      if (core_key_load) begin
        kcnt    <= KEY_LAT;
        key_rdy <= 1'b0;
      end else if (kcnt > 0) begin
        kcnt <= kcnt - 1;
        if (kcnt == 1) key_rdy <= 1'b1;
      end
      if (core_start) begin
        mcnt <= model_never ? 0 : LAT;
      end else if (mcnt > 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) begin
          model_done <= 1'b1;
          model_dout <= core_fn(core_key, core_din, core_dec);
        end
      end
    end
  end

  always @(negedge ACLK) begin
    if (irq) begin
      irq_cnt <= irq_cnt + 1;
      check("irq_single", irq_prev, 1'b0);
    end
    irq_prev <= irq;
    if (core_start) start_cnt <= start_cnt + 1;
    if (core_done) last_done_c <= cyc;
    if (res_valid && irq && busy) begin
      if (exp_q.size() == 0) begin
        check("sb_pending", 128'(exp_q.size()), 128'd1);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_res_data", res_data, sb_e.data);
        check("sb_core_dec", core_dec, sb_e.dec);
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op, input block_t key, input block_t blk);
    cmd_op    = op;
    key_in    = key;
    blk_in    = blk;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge ACLK);
    check("cmd_accept", cmd_ready, 1'b1);
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) @(negedge ACLK);
    @(negedge ACLK);
    check("idle_reached", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int     i0, s0, sc, hs;
    block_t b1, b2, k1, bx;

    repeat (3) @(negedge ACLK);
    check("rst_misc", {busy, res_valid, key_loaded, err_code, blk_count, irq,
                       core_start, core_key_load, core_dec}, '0);
    check("rst_key", core_key, '0);
    check("rst_din", core_din, '0);
    check("rst_res", res_data, '0);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("rst_cmd_ready", cmd_ready, 1'b1);

    // Encrypt with no key loaded.
    i0 = irq_cnt; s0 = start_cnt;
    send_cmd(OP_ENCRYPT, '0, PT0);
    check("nokey_err", err_code, ERR_NO_KEY);
    check("nokey_ready", cmd_ready, 1'b1);
    repeat (3) @(negedge ACLK);
    check("nokey_irq_cnt", irq_cnt - i0, 1);
    check("nokey_no_start", start_cnt - s0, 0);
    check("nokey_ready2", cmd_ready, 1'b1);

    // Key load, then the reference encrypt.
    i0 = irq_cnt;
    send_cmd(OP_LOAD_KEY, KEY0, '0);
    check("kl_pulse", core_key_load, 1'b1);
    wait_idle();
    check("kl_loaded", key_loaded, 1'b1);
    check("kl_key", core_key, KEY0);
    check("kl_irq_cnt", irq_cnt - i0, 1);
    i0 = irq_cnt;
    exp_q.push_back('{data: CT0, dec: 1'b0});
    send_cmd(OP_ENCRYPT, '0, PT0);
    check("enc_start", core_start, 1'b1);
    check("enc_dec", core_dec, 1'b0);
    wait_idle();
    check("enc_valid", res_valid, 1'b1);
    check("enc_res", res_data, CT0);
    check("enc_cnt", blk_count, 1);
    check("enc_irq_cnt", irq_cnt - i0, 1);

    // Back-to-back decrypt with cmd_valid held high.
    b1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    b2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    i0 = irq_cnt; hs = 0;
    exp_q.push_back('{data: core_fn(KEY0, b1, 1'b1), dec: 1'b1});
    cmd_op = OP_DECRYPT; blk_in = b1; cmd_valid = 1'b1;
    for (int g = 0; g < 200 && hs < 2; g++) begin
      if (cmd_ready) begin
        hs++;
        if (hs == 2) check("b2b_gap", cyc - last_done_c, 2);
        @(negedge ACLK);
        check("b2b_dec", core_dec, 1'b1);
        if (hs == 1) begin
          blk_in = b2;
          exp_q.push_back('{data: core_fn(KEY0, b2, 1'b1), dec: 1'b1});
        end
      end else begin
        @(negedge ACLK);
      end
    end
    cmd_valid = 1'b0;
    check("b2b_hs", hs, 2);
    wait_idle();
    check("b2b_cnt", blk_count, 3);
    check("b2b_irq_cnt", irq_cnt - i0, 2);

    // Abort in BLK_WAIT coinciding with core_done.
    model_never = 1'b1;
    send_cmd(OP_ENCRYPT, '0, PT0);
    @(negedge ACLK);
    check("ab_busy", busy, 1'b1);
    man_done = 1'b1; man_dout = ~CT0; abort = 1'b1;
    @(negedge ACLK);
    man_done = 1'b0; abort = 1'b0;
    check("ab_err", err_code, ERR_ABORT);
    check("ab_valid", res_valid, 1'b0);
    check("ab_cnt", blk_count, 3);
    check("ab_res_kept", res_data, core_fn(KEY0, b2, 1'b1));
    check("ab_idle", busy, 1'b0);
    check("ab_irq", irq, 1'b1);
    check("ab_key_kept", key_loaded, 1'b1);

    // Abort in IDLE is ignored; NOP clears the error without irq.
    @(negedge ACLK);
    i0 = irq_cnt;
    abort = 1'b1;
    @(negedge ACLK);
    abort = 1'b0;
    check("idle_abort_err", err_code, ERR_ABORT);
    send_cmd(OP_NOP, '0, '0);
    check("nop_err", err_code, ERR_NONE);
    check("nop_busy", busy, 1'b0);
    repeat (2) @(negedge ACLK);
    check("nop_irq_cnt", irq_cnt - i0, 0);

    // Timeout: core never completes.
    send_cmd(OP_ENCRYPT, '0, PT0);
    sc = cyc;
    check("to_start", core_start, 1'b1);
    for (int i = 0; i < 40 && err_code != ERR_TIMEOUT; i++) @(negedge ACLK);
    check("to_delay", cyc - sc, TO);
    check("to_err", err_code, ERR_TIMEOUT);
    check("to_key", key_loaded, 1'b0);
    check("to_idle", busy, 1'b0);
    check("to_cnt", blk_count, 3);

    // Reset in BLK_WAIT followed by a stray core_done.
    model_never = 1'b0;
    send_cmd(OP_LOAD_KEY, KEY0, '0);
    wait_idle();
    model_never = 1'b1;
    send_cmd(OP_ENCRYPT, '0, PT0);
    @(negedge ACLK);
    i0 = irq_cnt; s0 = start_cnt;
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    man_done = 1'b1; man_dout = CT0;
    @(negedge ACLK);
    man_done = 1'b0;
    repeat (2) @(negedge ACLK);
    check("rst2_misc", {busy, res_valid, key_loaded, err_code, blk_count, irq,
                        core_start, core_key_load, core_dec}, '0);
    check("rst2_key", core_key, '0);
    check("rst2_din", core_din, '0);
    check("rst2_res", res_data, '0);
    check("rst2_ready", cmd_ready, 1'b1);
    check("rst2_irq_cnt", irq_cnt - i0, 0);
    check("rst2_start_cnt", start_cnt - s0, 0);

    // Key reload and counter wrap.
    model_never = 1'b0;
    k1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_cmd(OP_LOAD_KEY, k1, '0);
    wait_idle();
    check("wrap_key", core_key, k1);
    for (int i = 0; i < 5; i++) begin
      bx = {$urandom(), $urandom(), $urandom(), $urandom()};
      exp_q.push_back('{data: core_fn(k1, bx, 1'b0), dec: 1'b0});
      send_cmd(OP_ENCRYPT, '0, bx);
      wait_idle();
      check("wrap_cnt", blk_count, (i + 1) % 4);
    end

    check("sb_drained", 128'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_seq_ctrl.md
# aes_seq_ctrl

Command sequencer between the AXI-Lite register file of the AES IP and the AES core. It accepts one host command at a time: load key, encrypt block or decrypt block. It drives the core's key-load and start handshakes, supervises completion with a timeout, and latches the 128-bit result plus status for the register file. It also raises a one-cycle interrupt.

## Interface
- TIMEOUT_CYCLES, default 1024: maximum cycles from core_start to core_done before the operation is aborted.
- CNT_W, default 32: width of the completed-block counter.
- ACLK  in  1  clock.
- ARESET  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  host command strobe.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  command: 0 NOP, 1 LOAD_KEY, 2 ENCRYPT, 3 DECRYPT.
- key_in  in  128  key; sampled on a LOAD_KEY handshake.
- blk_in  in  128  input block; sampled on an ENCRYPT/DECRYPT handshake.
- abort  in  1  soft abort; forces IDLE.
- core_key  out  128  registered key to the core.
- core_key_load  out  1  one-cycle key-expansion request.
- core_key_ready  in  1  core finished key expansion (level).
- core_din  out  128  registered block to the core.
- core_dec  out  1  0 encrypt, 1 decrypt; stable while busy.
- core_start  out  1  one-cycle start pulse.
- core_done  in  1  one-cycle completion pulse.
- core_dout  in  128  core result; valid with core_done.
- res_data  out  128  latched result.
- res_valid  out  1  res_data holds a fresh result.
- busy  out  1  state is not IDLE.
- key_loaded  out  1  a valid expanded key is present.
- err_code  out  2  0 none, 1 no key, 2 timeout, 3 aborted; sticky until next accepted command.
- blk_count  out  CNT_W  count of completed blocks; wraps.
- irq  out  1  one-cycle pulse on completion or error.

## Operation
- States: IDLE, KEY_REQ, KEY_WAIT, BLK_START, BLK_WAIT, CAPTURE.
- IDLE: cmd_ready=1. A handshake occurs when cmd_valid&&cmd_ready is sampled high on an ACLK edge. On a handshake, err_code is cleared and res_valid is cleared.
- NOP: the handshake completes with no state change and no irq.
- LOAD_KEY: core_key is loaded from key_in and key_loaded is cleared; go to KEY_REQ.
- KEY_REQ: core_key_load=1 for exactly one cycle; go to KEY_WAIT.
- KEY_WAIT: on core_key_ready, set key_loaded, pulse irq, and go to IDLE. The timeout applies here too.
- ENCRYPT/DECRYPT with key_loaded=0: no core activity; err_code=1, irq pulses, and the state stays IDLE.
- ENCRYPT/DECRYPT with a key: core_din is loaded from blk_in and core_dec from cmd_op[0]; go to BLK_START.
- BLK_START: core_start=1 for one cycle and the timeout counter is cleared; go to BLK_WAIT.
- BLK_WAIT: on core_done, capture core_dout into res_data and go to CAPTURE.
- CAPTURE: res_valid=1, blk_count increments, irq pulses; go to IDLE.
- Timeout: the counter reaches TIMEOUT_CYCLES-1 without done/ready. Set err_code=2, clear key_loaded, pulse irq, go to IDLE.
- abort in any non-IDLE state: err_code=3, irq pulses, go to IDLE next cycle, and key_loaded is cleared if abort arrives in KEY_REQ/KEY_WAIT. abort in IDLE is ignored.
- abort has priority over core_done and timeout in the same cycle.
- core_done or core_key_ready outside its wait state is ignored.
- A key may be reloaded at any time from IDLE. res_data is retained until the next result is captured.

## Timing
- Reset values: state IDLE; cmd_ready=1 in the first cycle after reset. All other outputs are 0, including core_key, core_din, res_data and blk_count.
- Reset mid-operation: everything returns to reset values on the next edge, with no irq and no core_start.
- ENCRYPT handshake at edge N: core_start high during cycle N+1.
- core_done sampled at edge M: res_data/res_valid/irq valid during cycle M+1 (CAPTURE). cmd_ready returns at M+2.
- Minimum block turnaround is the core latency plus 3 cycles.
- cmd_ready is low in all states except IDLE. Commands presented while busy are stalled, not dropped.
- irq is never high for two consecutive cycles.
- blk_count wraps from 2^CNT_W-1 to 0.

## Structure
- Package aes_seq_pkg: typedefs for cmd_op_e (NOP/LOAD_KEY/ENCRYPT/DECRYPT), state_e, err_e, and the 128-bit block_t.
- One sub-module: aes_seq_timeout, a loadable down-counter with clear and expired flag, parameterised by TIMEOUT_CYCLES.
- All other logic is one FSM module.

## Test plan
- Key load then encrypt: LOAD_KEY key=000102030405060708090a0b0c0d0e0f; core model ready after 10 cycles. Then ENCRYPT blk=00112233445566778899aabbccddeeff; model returns 69c4e0d86a7b0430d8cdb78070b4c55a. Required: res_data equals it, res_valid=1, blk_count=1, one irq per command, core_dec=0.
- Encrypt without key after reset: required err_code=1, irq once, core_start never asserted, cmd_ready stays 1.
- Timeout with TIMEOUT_CYCLES=16 and the model never asserting done: required err_code=2 exactly 16 cycles after core_start, key_loaded=0, state IDLE.
- abort asserted in BLK_WAIT on the same cycle as core_done: required err_code=3, res_valid=0, blk_count unchanged.
- Back-to-back DECRYPT with cmd_valid held high: required the second handshake at M+2, core_dec=1, no dropped command, blk_count +2.
- ARESET asserted in BLK_WAIT, then a stray core_done: required all outputs zero and the done ignored.
